// File: rtl/regfile_mp.sv
// regfile_mp: dual-write, multi-read register file with per-register pending-write (busy) tracking; optional same-cycle write-to-read bypass under REGFILE_MP_BYPASS_EN
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  regWrite0,
  input  logic [ADDR_W-1:0]     writeReg0,
  input  logic [DATA_W-1:0]     writeData0,
  input  logic                  regWrite1,
  input  logic [ADDR_W-1:0]     writeReg1,
  input  logic [DATA_W-1:0]     writeData1,
  input  logic                  resvEn,
  input  logic [ADDR_W-1:0]     resvReg,
  input  logic [NRD*ADDR_W-1:0] readReg,
  output logic [NRD*DATA_W-1:0] readData,
  output logic [NRD-1:0]        readBusy
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic we0, we1, rv;
  // Register 0 is hardwired to zero, so writes and reserves aimed at it are dropped here
  assign we0 = regWrite0 && writeReg0 != '0;
  assign we1 = regWrite1 && writeReg1 != '0;
  assign rv  = resvEn && resvReg != '0;
  // Next state: port 1 overrides port 0, and a reserve overrides the busy-clear of a write
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (we0) begin
      mem_d[writeReg0]  = writeData0;
      busy_d[writeReg0] = 1'b0;
    end
    if (we1) begin
      mem_d[writeReg1]  = writeData1;
      busy_d[writeReg1] = 1'b0;
    end
    if (rv) busy_d[resvReg] = 1'b1;
  end
  // State update; reset discards all data, reservations and any same-cycle writes
  always_ff @(posedge clock_in) begin
    if (reset) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = readReg[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_MP_BYPASS_EN
    logic h0, h1;
    assign h0 = we0 && writeReg0 == a;
    assign h1 = we1 && writeReg1 == a;
    assign readData[k*DATA_W +: DATA_W] = h1 ? writeData1 : h0 ? writeData0 : mem_q[a];
    assign readBusy[k] = (h0 || h1) ? (rv && resvReg == a) : busy_q[a];
`else
    assign readData[k*DATA_W +: DATA_W] = mem_q[a];
    assign readBusy[k] = busy_q[a];
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default 32x32, two read ports)
module tb_regfile_mp;
  logic        clock_in = 1'b0;
  logic        reset = 1'b1;
  logic        regWrite0 = 1'b0, regWrite1 = 1'b0, resvEn = 1'b0;
  logic [4:0]  writeReg0 = '0, writeReg1 = '0, resvReg = '0;
  logic [31:0] writeData0 = '0, writeData1 = '0;
  logic [9:0]  readReg = '0;
  logic [63:0] readData;
  logic [1:0]  readBusy;
  int checks = 0;
  int failures = 0;

  regfile_mp dut (
    .clock_in(clock_in), .reset(reset),
    .regWrite0(regWrite0), .writeReg0(writeReg0), .writeData0(writeData0),
    .regWrite1(regWrite1), .writeReg1(writeReg1), .writeData1(writeData1),
    .resvEn(resvEn), .resvReg(resvReg),
    .readReg(readReg), .readData(readData), .readBusy(readBusy)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    readReg = {a1, a0};
    #1;
  endtask

  task automatic idle();
    regWrite0 = 1'b0;
    regWrite1 = 1'b0;
    resvEn = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      chk($sformatf("rst_data0_%0d", a), readData[31:0], 32'h0);
      chk($sformatf("rst_data1_%0d", a), readData[63:32], 32'h0);
      chk($sformatf("rst_busy_%0d", a), {30'b0, readBusy}, 32'h0);
    end

    regWrite0 = 1'b1; writeReg0 = 5'd21; writeData0 = 32'hFAFA0C0C;
    tick();
    idle();
    rd(5'd0, 5'd21);
    chk("wr21_p1", readData[63:32], 32'hFAFA0C0C);
    chk("wr21_p0_zero", readData[31:0], 32'h0);
    regWrite0 = 1'b1; writeReg0 = 5'd0; writeData0 = 32'h12345678;
    tick();
    idle();
    rd(5'd0, 5'd0);
    chk("wr0_ignored", readData[31:0], 32'h0);
    chk("wr0_busy", {30'b0, readBusy}, 32'h0);

    regWrite0 = 1'b1; writeReg0 = 5'd10; writeData0 = 32'h11111111;
    regWrite1 = 1'b1; writeReg1 = 5'd10; writeData1 = 32'hABCDABCD;
    tick();
    idle();
    rd(5'd10, 5'd21);
    chk("same_addr_p1_wins", readData[31:0], 32'hABCDABCD);
    chk("reg21_kept", readData[63:32], 32'hFAFA0C0C);
    regWrite0 = 1'b1; writeReg0 = 5'd5; writeData0 = 32'h5;
    regWrite1 = 1'b1; writeReg1 = 5'd6; writeData1 = 32'h6;
    tick();
    idle();
    rd(5'd5, 5'd6);
    chk("dual_wr5", readData[31:0], 32'h5);
    chk("dual_wr6", readData[63:32], 32'h6);

    resvEn = 1'b1; resvReg = 5'd7;
    tick();
    idle();
    rd(5'd7, 5'd6);
    chk("resv7_busy", {30'b0, readBusy}, 32'h1);
    chk("resv7_data", readData[31:0], 32'h0);
    resvEn = 1'b1; resvReg = 5'd0;
    tick();
    idle();
    rd(5'd0, 5'd7);
    chk("resv0_ignored", {30'b0, readBusy}, 32'h2);
    regWrite1 = 1'b1; writeReg1 = 5'd7; writeData1 = 32'h77;
    tick();
    idle();
    rd(5'd7, 5'd7);
    chk("wr7_clears_busy", {30'b0, readBusy}, 32'h0);
    chk("wr7_data", readData[31:0], 32'h77);
    regWrite0 = 1'b1; writeReg0 = 5'd7; writeData0 = 32'h99;
    resvEn = 1'b1; resvReg = 5'd7;
    tick();
    idle();
    rd(5'd7, 5'd5);
    chk("resv_wr7_busy", {30'b0, readBusy}, 32'h1);
    chk("resv_wr7_data", readData[31:0], 32'h99);
    resvEn = 1'b1; resvReg = 5'd7;
    tick();
    idle();
    rd(5'd5, 5'd7);
    chk("resv_again_busy", {30'b0, readBusy}, 32'h2);
    writeReg0 = 5'd7; writeData0 = 32'hBAD0BAD0;
    writeReg1 = 5'd21; writeData1 = 32'hBAD1BAD1;
    tick();
    rd(5'd7, 5'd21);
    chk("wr_dis_busy", {30'b0, readBusy}, 32'h1);
    chk("wr_dis_data7", readData[31:0], 32'h99);
    chk("wr_dis_data21", readData[63:32], 32'hFAFA0C0C);

    regWrite0 = 1'b1; writeReg0 = 5'd3; writeData0 = 32'hDEADBEEF;
    rd(5'd3, 5'd4);
`ifdef REGFILE_MP_BYPASS_EN
    chk("same_cycle_rd3", readData[31:0], 32'hDEADBEEF);
`else
    chk("same_cycle_rd3", readData[31:0], 32'h0);
`endif
    chk("same_cycle_busy3", {30'b0, readBusy}, 32'h0);
    tick();
    idle();
    rd(5'd3, 5'd7);
    chk("post_edge_rd3", readData[31:0], 32'hDEADBEEF);
    chk("pre_reset_busy7", {30'b0, readBusy}, 32'h2);

    reset = 1'b1;
    regWrite1 = 1'b1; writeReg1 = 5'd9; writeData1 = 32'h9999;
    resvEn = 1'b1; resvReg = 5'd12;
    tick();
    reset = 1'b0;
    idle();
    rd(5'd7, 5'd12);
    chk("rst_mid_busy", {30'b0, readBusy}, 32'h0);
    chk("rst_mid_data7", readData[31:0], 32'h0);
    rd(5'd9, 5'd21);
    chk("rst_mid_wr9", readData[31:0], 32'h0);
    chk("rst_mid_data21", readData[63:32], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
